lpc_record_packer: RTL

- Downstream of the LPC bus decoder: captures each completed LPC transaction (cycle type/direction, address, data, size) and buffers it in a small record FIFO.
- Serialises each record into a fixed-length byte stream on a valid/ready interface that feeds the sniffer's UART transmitter.
- Absorbs bursts of back-to-back LPC cycles while the slow UART drains; on overflow, drops and counts records rather than stalling.

---
 rtl/lpc_record_packer_pkg.sv | 26 ++
 rtl/lpc_record_packer_if.sv | 9 +
 rtl/lpc_record_packer_fifo.sv | 56 +++++
 rtl/lpc_record_packer.sv | 116 +++++++++++
 4 files changed

// File: rtl/lpc_record_packer_pkg.sv
// Shared constants and types for the LPC record packer.
// Build option: LPC_PACKER_SYNC_EN prefixes every record with a sync byte.
package lpc_pkg;

  localparam logic [3:0] CT_IO_RD  = 4'b0000;
  localparam logic [3:0] CT_IO_WR  = 4'b0010;
  localparam logic [3:0] CT_MEM_RD = 4'b0100;
  localparam logic [3:0] CT_MEM_WR = 4'b0110;

  localparam int unsigned REC_W     = 72;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

`ifdef LPC_PACKER_SYNC_EN
  localparam int unsigned NBYTES = 10;
`else
  localparam int unsigned NBYTES = 9;
`endif

  localparam int unsigned SHIFT_W = NBYTES * 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SEND
  } pack_state_e;

endpackage

// File: rtl/lpc_record_packer_if.sv
// Byte stream from the packer towards the UART transmitter.
interface lpc_record_packer_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_byte, output out_valid, input out_ready);
  modport slave  (input out_byte, input out_valid, output out_ready);
endinterface

// File: rtl/lpc_record_packer_fifo.sv
// Record FIFO: power-of-two depth, push into a full FIFO allowed when a pop
// happens in the same cycle.
module lpc_record_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   lpc_clock,
  input  logic                   lpc_reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (count != '0);
    do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    level    = count;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge lpc_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lpc_record_packer.sv
// Captures completed LPC transactions into a record FIFO and serialises them
// as a byte stream. Build option: LPC_PACKER_SYNC_EN (leading 8'hA5 sync byte).
module lpc_record_packer
  import lpc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                      lpc_clock,
  input  logic                      lpc_reset,
  input  logic [3:0]                in_cyctype_dir,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_data,
  input  logic [3:0]                in_data_size,
  input  logic                      in_strobe,
  lpc_record_packer_if.master       stream,
  output logic [CNT_W-1:0]          drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  pack_state_e        state;
  pack_state_e        state_next;
  logic               strobe_q;
  logic               capture;
  logic [REC_W-1:0]   record;
  logic [REC_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               handshake;
  logic               last_byte;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] load_value;
  logic [3:0]         idx;

  assign capture = in_strobe && !strobe_q;
  assign record  = {in_cyctype_dir, in_data_size, in_addr, in_data};

`ifdef LPC_PACKER_SYNC_EN
  assign load_value = {SYNC_BYTE, head};
`else
  assign load_value = head;
`endif

  lpc_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .push      (capture),
    .push_data (record),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_next       = state;
    stream.out_valid = 1'b0;
    stream.out_byte  = '0;
    handshake        = 1'b0;
    last_byte        = (idx == 4'(NBYTES - 1));
    pop              = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        stream.out_valid = 1'b1;
        stream.out_byte  = shift[SHIFT_W-1 -: 8];
        handshake        = stream.out_ready;
        // Chain straight into the next record on the final byte to avoid a bubble.
        if (handshake && last_byte) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      state    <= ST_IDLE;
      strobe_q <= 1'b0;
      shift    <= '0;
      idx      <= '0;
    end else begin
      state    <= state_next;
      strobe_q <= in_strobe;
      if (pop) begin
        shift <= load_value;
        idx   <= '0;
      end else if (handshake) begin
        shift <= shift << 8;
        idx   <= idx + 4'd1;
      end
    end
  end

  // A capture is only lost when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      drop_count <= '0;
    end else if (capture && fifo_full && !pop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule
